// File: rtl/baud_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : baud_pkg
//  Description : Shared constants, OSR legality check and divisor-pair type
//                for the fractional baud-rate generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package baud_pkg;

  // Default widths and oversample ratio for the generator
  localparam int IBRD_W_DEF = 16;
  localparam int FBRD_W_DEF = 6;
  localparam int OSR_DEF    = 16;

  // Widest divisor fields the shared pair type can carry
  localparam int DIV_I_MAX_W = 32;
  localparam int DIV_F_MAX_W = 16;

  // Integer / fractional divisor pair, zero-extended to the maximum widths
  typedef struct packed {
    logic [DIV_I_MAX_W-1:0] int_div;
    logic [DIV_F_MAX_W-1:0] frac_div;
  } div_pair_t;

  // Only 8x and 16x oversampling are supported
  function automatic bit osr_is_legal(input int osr);
    return (osr == 8) || (osr == 16);
  endfunction

endpackage : baud_pkg
`default_nettype wire

// File: rtl/frac_div_core.sv
`default_nettype none
// ============================================================================
//  Module      : frac_div_core
//  Description : Period counter plus fractional accumulator. Produces one
//                registered os_tick per period of act_i (or act_i+1 after an
//                accumulator carry) enabled cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module frac_div_core
  import baud_pkg::*;
#(
  parameter int IBRD_W = IBRD_W_DEF,
  parameter int FBRD_W = FBRD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [IBRD_W-1:0] act_i,
  input  logic [FBRD_W-1:0] act_f,
  output logic              period_end,
  output logic              os_tick
);

  logic [IBRD_W-1:0] r_cnt;
  logic [FBRD_W-1:0] r_acc;
  logic              r_extra;
  logic              r_os_tick;

  logic [IBRD_W:0]   w_len;
  logic [IBRD_W:0]   w_cnt_next;
  logic [FBRD_W:0]   w_sum;

  // Current period length is the integer part, stretched by one cycle when
  // the previous accumulator add carried out.
  assign w_len      = {1'b0, act_i} + {{IBRD_W{1'b0}}, r_extra};
  assign w_cnt_next = {1'b0, r_cnt} + {{IBRD_W{1'b0}}, 1'b1};
  // ">=" rather than "==" so a divisor shrunk while disabled cannot strand
  // the counter above the new terminal count.
  assign period_end = enable && (w_cnt_next >= w_len);
  assign w_sum      = {1'b0, r_acc} + {1'b0, act_f};

  assign os_tick    = r_os_tick;

  // Count enabled cycles; at each period end, restart and accumulate fraction
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_extra   <= 1'b0;
      r_os_tick <= 1'b0;
    end else begin
      r_os_tick <= period_end;
      if (period_end) begin
        r_cnt   <= '0;
        r_acc   <= w_sum[FBRD_W-1:0];
        r_extra <= w_sum[FBRD_W];
      end else if (enable) begin
        r_cnt   <= w_cnt_next[IBRD_W-1:0];
      end
    end
  end

endmodule : frac_div_core
`default_nettype wire

// File: rtl/frac_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : frac_baud_gen
//  Description : Fractional baud-rate generator. Holds the active / shadow
//                divisor registers and derives bit_tick and baud_clk from the
//                oversample tick produced by frac_div_core.
//  Revision    : 1.0 - initial release
// ============================================================================
module frac_baud_gen
  import baud_pkg::*;
#(
  parameter int IBRD_W   = IBRD_W_DEF,
  parameter int FBRD_W   = FBRD_W_DEF,
  parameter int OSR      = OSR_DEF,
  parameter int DEF_IBRD = 1,
  parameter int DEF_FBRD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [IBRD_W-1:0] ibrd,
  input  logic [FBRD_W-1:0] fbrd,
  input  logic              load,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              baud_clk,
  output logic              upd_pend,
  output logic              div_err
);

  localparam int                CNT_W     = $clog2(OSR);
  localparam logic [CNT_W-1:0]  OS_LAST   = CNT_W'(OSR - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(OSR / 2 - 1);

  // Reject unsupported configurations at elaboration
  if (!osr_is_legal(OSR)) begin : g_osr_check
    $error("frac_baud_gen: OSR must be 8 or 16");
  end
  if (DEF_IBRD < 1) begin : g_def_ibrd_check
    $error("frac_baud_gen: DEF_IBRD must be at least 1");
  end

  logic [IBRD_W-1:0] r_act_i;
  logic [FBRD_W-1:0] r_act_f;
  div_pair_t         r_shadow;
  logic              r_upd_pend;
  logic              r_div_err;
  logic [CNT_W-1:0]  r_os_cnt;
  logic              r_bit_tick;
  logic              r_baud_clk;

  logic              w_period_end;
  logic              w_load_ok;
  logic              w_load_zero;
  logic              w_shadow_unused;

  assign w_load_ok   = load && (ibrd != '0);
  assign w_load_zero = load && (ibrd == '0);

  // Upper bits of the shared pair type are always zero for narrow builds
  assign w_shadow_unused = ^r_shadow;

  frac_div_core #(
    .IBRD_W (IBRD_W),
    .FBRD_W (FBRD_W)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .act_i      (r_act_i),
    .act_f      (r_act_f),
    .period_end (w_period_end),
    .os_tick    (os_tick)
  );

  // Divisor update: immediate while stopped, otherwise deferred to the end of
  // the running period. A load landing on the period-end edge itself goes
  // straight to the active pair so it governs the very next period.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_act_i    <= IBRD_W'(DEF_IBRD);
      r_act_f    <= FBRD_W'(DEF_FBRD);
      r_shadow   <= '0;
      r_upd_pend <= 1'b0;
      r_div_err  <= 1'b0;
    end else begin
      if (w_load_zero) begin
        r_div_err <= 1'b1;
      end
      if (!enable) begin
        if (w_load_ok) begin
          r_act_i    <= ibrd;
          r_act_f    <= fbrd;
          r_upd_pend <= 1'b0;
        end
      end else if (w_period_end) begin
        if (w_load_ok) begin
          r_act_i <= ibrd;
          r_act_f <= fbrd;
        end else if (r_upd_pend) begin
          r_act_i <= r_shadow.int_div[IBRD_W-1:0];
          r_act_f <= r_shadow.frac_div[FBRD_W-1:0];
        end
        r_upd_pend <= 1'b0;
      end else if (w_load_ok) begin
        r_shadow.int_div  <= DIV_I_MAX_W'(ibrd);
        r_shadow.frac_div <= DIV_F_MAX_W'(fbrd);
        r_upd_pend        <= 1'b1;
      end
    end
  end

  // Oversample counter: bit_tick on wrap, baud_clk toggles at half and wrap
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_os_cnt   <= '0;
      r_bit_tick <= 1'b0;
      r_baud_clk <= 1'b0;
    end else begin
      r_bit_tick <= w_period_end && (r_os_cnt == OS_LAST);
      if (w_period_end) begin
        r_os_cnt <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + 1'b1;
        if ((r_os_cnt == HALF_LAST) || (r_os_cnt == OS_LAST)) begin
          r_baud_clk <= ~r_baud_clk;
        end
      end
    end
  end

  assign bit_tick = r_bit_tick;
  assign baud_clk = r_baud_clk;
  assign upd_pend = r_upd_pend;
  assign div_err  = r_div_err;

endmodule : frac_baud_gen
`default_nettype wire
